// File: rtl/alu_resp_checker.sv
// Response-side checker for the 40-bit ALU: recomputes each captured a/b/s result,
// delays it by the ALU latency and compares it with alu_out, keeping counters and a first-failure snapshot.
module alu_resp_checker #(
    parameter int WIDTH       = 40,
    parameter int SEL_W       = 5,
    parameter int LAT         = 1,
    parameter int CNT_W       = 16,
    parameter int HALT_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SEL_W-1:0] s,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             clr,
    output logic             mismatch,
    output logic             err_sticky,
    output logic             halted,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] skip_cnt,
    output logic [SEL_W-1:0] fe_sel,
    output logic [WIDTH-1:0] fe_exp,
    output logic [WIDTH-1:0] fe_got
);

    localparam logic [SEL_W-1:0] OP_PASSA = SEL_W'(0);
    localparam logic [SEL_W-1:0] OP_ADD   = SEL_W'(5);
    localparam logic [SEL_W-1:0] OP_SUB   = SEL_W'(6);
    localparam logic [SEL_W-1:0] OP_OR    = SEL_W'(7);
    localparam logic [SEL_W-1:0] OP_AND   = SEL_W'(8);
    localparam logic [SEL_W-1:0] OP_XOR   = SEL_W'(11);
    localparam logic [SEL_W-1:0] OP_SHL   = SEL_W'(12);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;

    state_t                        state_q;
    logic [LAT-1:0]                vld_q;
    logic [LAT-1:0]                sup_q;
    logic [LAT-1:0][SEL_W-1:0]     sel_q;
    logic [LAT-1:0][WIDTH-1:0]     exp_q;

    logic             mismatch_q, err_sticky_q;
    logic [CNT_W-1:0] chk_cnt_q, err_cnt_q, skip_cnt_q;
    logic [SEL_W-1:0] fe_sel_q;
    logic [WIDTH-1:0] fe_exp_q, fe_got_q;

    logic [WIDTH-1:0] exp_d;
    logic             sup_d;
    logic [5:0]       sh_amt;
    logic             cap_en, tail_live, do_cmp, do_skip, fail;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign sh_amt = b[5:0];

    always_comb begin
        exp_d = '0;
        sup_d = 1'b1;
        case (s)
            OP_PASSA: exp_d = a;
            OP_ADD:   exp_d = a + b;
            OP_SUB:   exp_d = a - b;
            OP_OR:    exp_d = a | b;
            OP_AND:   exp_d = a & b;
            OP_XOR:   exp_d = a ^ b;
            OP_SHL:   exp_d = (32'(sh_amt) >= WIDTH) ? '0 : (a << sh_amt);
            default:  sup_d = 1'b0;
        endcase
    end

    // HALT freezes both ends: nothing new enters and whatever is in flight is never judged.
    assign cap_en    = in_valid && (state_q != ST_HALT);
    assign tail_live = vld_q[LAT-1] && (state_q != ST_HALT);
    assign do_cmp    = tail_live && sup_q[LAT-1];
    assign do_skip   = tail_live && !sup_q[LAT-1];
    assign fail      = do_cmp && (exp_q[LAT-1] != alu_out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            vld_q        <= '0;
            sup_q        <= '0;
            sel_q        <= '0;
            exp_q        <= '0;
            mismatch_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            chk_cnt_q    <= '0;
            err_cnt_q    <= '0;
            skip_cnt_q   <= '0;
            fe_sel_q     <= '0;
            fe_exp_q     <= '0;
            fe_got_q     <= '0;
        end else if (clr) begin
            state_q      <= ST_IDLE;
            vld_q        <= '0;
            mismatch_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            chk_cnt_q    <= '0;
            err_cnt_q    <= '0;
            skip_cnt_q   <= '0;
            fe_sel_q     <= '0;
            fe_exp_q     <= '0;
            fe_got_q     <= '0;
        end else begin
            vld_q[0] <= cap_en;
            sup_q[0] <= sup_d;
            sel_q[0] <= s;
            exp_q[0] <= exp_d;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                sup_q[i] <= sup_q[i-1];
                sel_q[i] <= sel_q[i-1];
                exp_q[i] <= exp_q[i-1];
            end

            mismatch_q <= fail;
            if (do_cmp)  chk_cnt_q  <= sat_inc(chk_cnt_q);
            if (do_skip) skip_cnt_q <= sat_inc(skip_cnt_q);
            if (fail) begin
                err_cnt_q <= sat_inc(err_cnt_q);
                if (!err_sticky_q) begin
                    err_sticky_q <= 1'b1;
                    fe_sel_q     <= sel_q[LAT-1];
                    fe_exp_q     <= exp_q[LAT-1];
                    fe_got_q     <= alu_out;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (fail && HALT_ON_ERR != 0) state_q <= ST_HALT;
                    else if (in_valid)            state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (fail && HALT_ON_ERR != 0) state_q <= ST_HALT;
                end
                default: state_q <= ST_HALT;
            endcase
        end
    end

    assign mismatch   = mismatch_q;
    assign err_sticky = err_sticky_q;
    assign halted     = (state_q == ST_HALT);
    assign chk_cnt    = chk_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign skip_cnt   = skip_cnt_q;
    assign fe_sel     = fe_sel_q;
    assign fe_exp     = fe_exp_q;
    assign fe_got     = fe_got_q;

endmodule

// File: tb/tb_alu_resp_checker.sv
// Bench for alu_resp_checker: three instances (LAT=1; LAT=3 with halt; LAT=2 with 4-bit counters)
// share one stimulus stream, each fed an ALU output delayed by its own latency.
module tb_alu_resp_checker;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, clr;
    logic [39:0] a, b;
    logic [4:0]  s;
    logic [39:0] alu_out0, alu_out1, alu_out2;
    logic [39:0] hist [0:3];

    logic m0_mm, m0_st, m0_h; logic [15:0] m0_chk, m0_err, m0_skip;
    logic [4:0] m0_fsel; logic [39:0] m0_fexp, m0_fgot;
    logic m1_mm, m1_st, m1_h; logic [15:0] m1_chk, m1_err, m1_skip;
    logic [4:0] m1_fsel; logic [39:0] m1_fexp, m1_fgot;
    logic m2_mm, m2_st, m2_h; logic [3:0] m2_chk, m2_err, m2_skip;
    logic [4:0] m2_fsel; logic [39:0] m2_fexp, m2_fgot;

    int n_chk = 0, n_err = 0;
    int p0 = 0, p1 = 0, p2 = 0;

    always #5 clk = ~clk;

    alu_resp_checker #(.LAT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .s(s), .alu_out(alu_out0),
        .clr(clr), .mismatch(m0_mm), .err_sticky(m0_st), .halted(m0_h), .chk_cnt(m0_chk),
        .err_cnt(m0_err), .skip_cnt(m0_skip), .fe_sel(m0_fsel), .fe_exp(m0_fexp), .fe_got(m0_fgot));

    alu_resp_checker #(.LAT(3), .HALT_ON_ERR(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .s(s), .alu_out(alu_out1),
        .clr(clr), .mismatch(m1_mm), .err_sticky(m1_st), .halted(m1_h), .chk_cnt(m1_chk),
        .err_cnt(m1_err), .skip_cnt(m1_skip), .fe_sel(m1_fsel), .fe_exp(m1_fexp), .fe_got(m1_fgot));

    alu_resp_checker #(.LAT(2), .CNT_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .s(s), .alu_out(alu_out2),
        .clr(clr), .mismatch(m2_mm), .err_sticky(m2_st), .halted(m2_h), .chk_cnt(m2_chk),
        .err_cnt(m2_err), .skip_cnt(m2_skip), .fe_sel(m2_fsel), .fe_exp(m2_fexp), .fe_got(m2_fgot));

    // Reference ALU: plain 64-bit arithmetic truncated to 40 bits.
    function automatic logic [39:0] alu_ref(input logic [39:0] ra, input logic [39:0] rb, input logic [4:0] rs);
        logic [63:0] xa, xb, r;
        int sh;
        xa = {24'd0, ra}; xb = {24'd0, rb}; sh = int'(rb[5:0]); r = 64'd0;
        case (rs)
            5'd0:  r = xa;
            5'd5:  r = xa + xb;
            5'd6:  r = xa - xb;
            5'd7:  r = xa | xb;
            5'd8:  r = xa & xb;
            5'd11: r = xa ^ xb;
            5'd12: r = (sh >= 40) ? 64'd0 : (xa << sh);
            default: r = 64'd0;
        endcase
        return r[39:0];
    endfunction

    function automatic bit is_sup(input logic [4:0] rs);
        return rs inside {5'd0, 5'd5, 5'd6, 5'd7, 5'd8, 5'd11, 5'd12};
    endfunction

    function automatic logic [39:0] rnd40();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[39:0];
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // One clock: present inputs, hand each ALU port the result issued LAT cycles ago, sample at edge+1.
    task automatic drive(input logic iv, input logic [39:0] ta, input logic [39:0] tb,
                         input logic [4:0] ts, input logic [39:0] taout);
        in_valid = iv; a = ta; b = tb; s = ts;
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = taout;
        alu_out0 = hist[1]; alu_out1 = hist[3]; alu_out2 = hist[2];
        @(posedge clk); #1;
        if (m0_mm) p0++;
        if (m1_mm) p1++;
        if (m2_mm) p2++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, rnd40(), rnd40(), 5'd5, rnd40());
    endtask

    task automatic do_clr();
        clr = 1'b1;
        drive(1'b1, 40'h5, 40'h3, 5'd5, 40'h8);
        clr = 1'b0;
    endtask

    typedef struct {
        logic [39:0] a;
        logic [39:0] b;
        logic [4:0]  s;
        logic        sup;
        logic [39:0] exp;
    } vec_t;

    vec_t vt [14];

    initial begin
        logic [4:0]  ops [7];
        logic        prev_mm, iv, sup, fault;
        logic [4:0]  rs;
        logic [39:0] ra, rb, rexp, raout, pat;
        int          m_chk, m_err, m_skip;
        logic        m_first;
        logic [4:0]  f_sel;
        logic [39:0] f_exp, f_got;
        int          pb;

        ops = '{5'd0, 5'd5, 5'd6, 5'd7, 5'd8, 5'd11, 5'd12};
        vt[0]  = '{40'h123456789A, 40'hFFFF,       5'd0,  1'b1, 40'h123456789A};
        vt[1]  = '{40'h0B,         40'h03,         5'd5,  1'b1, 40'h0E};
        vt[2]  = '{40'h0B,         40'h03,         5'd6,  1'b1, 40'h08};
        vt[3]  = '{40'h0B,         40'h03,         5'd7,  1'b1, 40'h0B};
        vt[4]  = '{40'h0B,         40'h03,         5'd8,  1'b1, 40'h03};
        vt[5]  = '{40'h0B,         40'h03,         5'd11, 1'b1, 40'h08};
        vt[6]  = '{40'h0B,         40'h04,         5'd12, 1'b1, 40'hB0};
        vt[7]  = '{40'h0,          40'h1,          5'd6,  1'b1, 40'hFFFFFFFFFF};
        vt[8]  = '{40'hFFFFFFFFFF, 40'h1,          5'd5,  1'b1, 40'h0};
        vt[9]  = '{40'h1,          40'd40,         5'd12, 1'b1, 40'h0};
        vt[10] = '{40'h1,          40'd39,         5'd12, 1'b1, 40'h8000000000};
        vt[11] = '{40'h1,          40'd67,         5'd12, 1'b1, 40'h8};
        vt[12] = '{40'h0B,         40'h03,         5'h1F, 1'b0, 40'h0};
        vt[13] = '{40'h0B,         40'h03,         5'd1,  1'b0, 40'h0};

        for (int i = 0; i < 4; i++) hist[i] = 40'h0;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; a = '0; b = '0; s = '0;
        alu_out0 = '0; alu_out1 = '0; alu_out2 = '0;

        // Reset with alu_out toggling, then quiet release.
        drive(1'b1, 40'h0B, 40'h3, 5'd5, 40'hFFFFFFFFFF);
        drive(1'b1, 40'h0B, 40'h3, 5'd6, 40'h0);
        drive(1'b1, 40'h0B, 40'h3, 5'd8, 40'hAAAAAAAAAA);
        check("rst_u0_zero", |{m0_mm, m0_st, m0_h, m0_chk, m0_err, m0_skip, m0_fsel, m0_fexp, m0_fgot}, 0);
        check("rst_u1_zero", |{m1_mm, m1_st, m1_h, m1_chk, m1_err, m1_skip, m1_fsel, m1_fexp, m1_fgot}, 0);
        check("rst_u2_zero", |{m2_mm, m2_st, m2_h, m2_chk, m2_err, m2_skip, m2_fsel, m2_fexp, m2_fgot}, 0);
        rst_n = 1'b1;
        idle(10);
        check("idle_u0_cnt", |{m0_chk, m0_err, m0_skip, m0_st, m0_h}, 0);
        check("idle_u1_cnt", |{m1_chk, m1_err, m1_skip, m1_st, m1_h}, 0);
        check("idle_pulses", p0 + p1 + p2, 0);

        // Four ops back-to-back with a correct ALU.
        pb = p0;
        drive(1'b1, 40'h0B, 40'h3, 5'd5,  40'h0E);
        drive(1'b1, 40'h0B, 40'h3, 5'd6,  40'h08);
        drive(1'b1, 40'h0B, 40'h3, 5'd8,  40'h03);
        drive(1'b1, 40'h0B, 40'h3, 5'd11, 40'h08);
        idle(2);
        check("ops_chk", m0_chk, 4);
        check("ops_err", m0_err, 0);
        check("ops_pulses", p0 - pb, 0);

        // Same stream with ADD returning 0x0F.
        do_clr();
        pb = p0;
        drive(1'b1, 40'h0B, 40'h3, 5'd5, 40'h0F);
        check("flt_mm_early", m0_mm, 0);
        drive(1'b1, 40'h0B, 40'h3, 5'd6, 40'h08);
        check("flt_mm_pulse", m0_mm, 1);
        drive(1'b1, 40'h0B, 40'h3, 5'd8, 40'h03);
        check("flt_mm_drop", m0_mm, 0);
        drive(1'b1, 40'h0B, 40'h3, 5'd11, 40'h08);
        idle(2);
        check("flt_pulses", p0 - pb, 1);
        check("flt_err", m0_err, 1);
        check("flt_chk", m0_chk, 4);
        check("flt_sticky", m0_st, 1);
        check("flt_fe_sel", m0_fsel, 5);
        check("flt_fe_exp", m0_fexp, 40'h0E);
        check("flt_fe_got", m0_fgot, 40'h0F);

        // clr landing on the compare edge of a faulty transaction wins.
        drive(1'b1, 40'h0B, 40'h3, 5'd5, 40'h0F);
        do_clr();
        check("clr_prio_mm", m0_mm, 0);
        check("clr_prio_cnt", |{m0_err, m0_chk, m0_st, m0_fexp}, 0);

        // Table: each vector once correct, then once with a one-bit fault.
        for (int i = 0; i < 14; i++) begin
            do_clr();
            drive(1'b1, vt[i].a, vt[i].b, vt[i].s, vt[i].exp);
            drive(1'b1, vt[i].a, vt[i].b, vt[i].s, vt[i].exp ^ 40'h1);
            check($sformatf("vec%0d_ok_mm", i), m0_mm, 0);
            idle(1);
            if (vt[i].sup) begin
                check($sformatf("vec%0d_mm", i), m0_mm, 1);
                check($sformatf("vec%0d_chk", i), m0_chk, 2);
                check($sformatf("vec%0d_fe_exp", i), m0_fexp, vt[i].exp);
                check($sformatf("vec%0d_fe_got", i), m0_fgot, vt[i].exp ^ 40'h1);
                check($sformatf("vec%0d_fe_sel", i), m0_fsel, vt[i].s);
            end else begin
                check($sformatf("vec%0d_mm", i), m0_mm, 0);
                check($sformatf("vec%0d_skip", i), m0_skip, 2);
                check($sformatf("vec%0d_chk", i), m0_chk, 0);
            end
        end

        // Randomised stream against the transaction-level model (LAT=1 instance).
        do_clr();
        prev_mm = 1'b0; m_chk = 0; m_err = 0; m_skip = 0; m_first = 1'b0;
        f_sel = '0; f_exp = '0; f_got = '0;
        for (int n = 0; n < 300; n++) begin
            iv = ($urandom_range(3) != 0);
            if ($urandom_range(9) < 8) rs = ops[$urandom_range(6)];
            else rs = 5'($urandom_range(31));
            ra = rnd40();
            rb = ($urandom_range(1) != 0) ? rnd40() : 40'($urandom_range(63));
            sup = is_sup(rs);
            fault = ($urandom_range(7) == 0);
            pat = rnd40();
            if (pat == 40'h0) pat = 40'h1;
            rexp = alu_ref(ra, rb, rs);
            raout = fault ? (rexp ^ pat) : rexp;
            drive(iv, ra, rb, rs, raout);
            check("rnd_mm", m0_mm, prev_mm);
            prev_mm = iv && sup && fault;
            if (iv && sup) begin
                m_chk++;
                if (fault) begin
                    m_err++;
                    if (!m_first) begin
                        m_first = 1'b1; f_sel = rs; f_exp = rexp; f_got = raout;
                    end
                end
            end else if (iv) begin
                m_skip++;
            end
        end
        idle(1);
        check("rnd_mm_last", m0_mm, prev_mm);
        check("rnd_chk", m0_chk, m_chk);
        check("rnd_err", m0_err, m_err);
        check("rnd_skip", m0_skip, m_skip);
        check("rnd_sticky", m0_st, m_first);
        check("rnd_fe_sel", m0_fsel, f_sel);
        check("rnd_fe_exp", m0_fexp, f_exp);
        check("rnd_fe_got", m0_fgot, f_got);

        // Halt: LAT=3, fault on the 2nd of 5 back-to-back transactions.
        do_clr();
        pb = p1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 40'(i + 1), 40'h2, 5'd5, (i == 1) ? 40'hDEAD : 40'(i + 3));
            if (i == 3) begin
                check("halt_pre_h", m1_h, 0);
                check("halt_pre_chk", m1_chk, 1);
            end
        end
        check("halt_mm", m1_mm, 1);
        check("halt_h", m1_h, 1);
        check("halt_chk", m1_chk, 2);
        check("halt_fe_got", m1_fgot, 40'hDEAD);
        check("halt_fe_exp", m1_fexp, 40'h4);
        for (int i = 0; i < 6; i++)
            drive(1'b1, rnd40(), rnd40(), (i == 2) ? 5'h1F : 5'd6, rnd40());
        idle(4);
        check("halt_hold_chk", m1_chk, 2);
        check("halt_hold_err", m1_err, 1);
        check("halt_hold_skip", m1_skip, 0);
        check("halt_hold_h", m1_h, 1);
        check("halt_pulses", p1 - pb, 1);
        do_clr();
        check("halt_clr", |{m1_h, m1_chk, m1_err, m1_skip, m1_st, m1_fsel, m1_fexp, m1_fgot}, 0);
        drive(1'b1, 40'h0B, 40'h3, 5'd7, 40'h0B);
        idle(4);
        check("halt_resume_chk", m1_chk, 1);
        check("halt_resume_err", m1_err, 0);

        // Reset mid-stream drops in-flight work (LAT=3 instance).
        do_clr();
        for (int i = 0; i < 4; i++) drive(1'b1, 40'h0B, 40'h3, 5'd5, 40'h1);
        check("mrst_pre_err", m1_err, 1);
        rst_n = 1'b0;
        #1;
        check("mrst_zero", |{m1_mm, m1_st, m1_h, m1_chk, m1_err, m1_fgot}, 0);
        idle(2);
        rst_n = 1'b1;
        pb = p1;
        idle(6);
        check("mrst_after", |{m1_chk, m1_err, m1_skip, m1_h}, 0);
        check("mrst_pulses", p1 - pb, 0);

        // Saturation on the 4-bit-counter instance.
        do_clr();
        pb = p2;
        for (int i = 0; i < 20; i++) drive(1'b1, 40'(100 + i), 40'h7, 5'd5, 40'(107 + i) ^ 40'hA5);
        idle(3);
        check("sat_err", m2_err, 15);
        check("sat_chk", m2_chk, 15);
        check("sat_pulses", p2 - pb, 20);
        check("sat_fe_sel", m2_fsel, 5);
        check("sat_fe_exp", m2_fexp, 40'd107);
        check("sat_fe_got", m2_fgot, 40'd107 ^ 40'hA5);
        do_clr();
        for (int i = 0; i < 20; i++) drive(1'b1, rnd40(), rnd40(), 5'h1F, rnd40());
        idle(3);
        check("sat_skip", m2_skip, 15);
        check("sat_skip_chk", m2_chk, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
